act_ingest_packer: RTL and testbench
====================================

// Module: act_ingest_packer
// PURPOSE
//  Packs a 32b external activation stream (valid/ready) into 256b words and writes them into the activation
//  buffer's internal write port, one full-width word per write. Sits directly upstream of the activation buffer
//  during activation load; a controller gives start / base / length, and the block reports busy / done.
// PARAMETERS
//  extInterfaceWidth  32    width of one input beat (bits)
//  intInterfaceWidth  256   width of one packed output word (bits); must be an integer multiple of extInterfaceWidth
//  dataSize           8     activation element width (bits)
//  depth              1024  buffer capacity in elements; wordsTotal = depth*dataSize/intInterfaceWidth (=32)
//  addrWidth          32    width of the word-address output
//  (local) beatsPerWord = intInterfaceWidth/extInterfaceWidth (=8); beatIdxW = $clog2(beatsPerWord)
// PORTS
//  clk           in   1                  clock, all state on rising edge
//  rst           in   1                  asynchronous reset, active-high
//  start_i       in   1                  one-cycle pulse: begin a transfer (sampled in IDLE only)
//  base_addr_i   in   addrWidth          first word address, sampled with start_i
//  num_words_i   in   addrWidth          words to write, sampled with start_i
//  s_data_i      in   extInterfaceWidth  input beat
//  s_valid_i     in   1                  input beat valid
//  s_last_i      in   1                  beat is final of stream; qualifies with s_valid_i
//  s_ready_o     out  1                  block accepts beat this cycle
//  m_wr_data_o   out  intInterfaceWidth  packed word to buffer
//  m_wr_addr_o   out  addrWidth          word address to buffer
//  m_wr_en_o     out  1                  write strobe, one cycle per word
//  m_ready_i     in   1                  buffer can take a write this cycle (backpressure)
//  busy_o        out  1                  high in FILL/EMIT
//  done_o        out  1                  one-cycle pulse at transfer end
//  word_count_o  out  addrWidth          words written in current/last transfer
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, beat index 0, pack register 0, counters 0. Reset mid-transfer drops the
//   partial word; no write is issued for it.
//  FSM: IDLE -start_i-> FILL (num_words_i==0: -> DONE). Also on start: word_count_o<=0, addr<=base_addr_i.
//   FILL -> EMIT when beat index beatsPerWord-1 accepted, or when a beat with s_last_i is accepted.
//   EMIT: m_wr_en_o=1. Stays in EMIT while m_ready_i=0 (data/addr/en held stable).
//   EMIT -> DONE when handshake completes and (word_count+1==num_words or last seen); else -> FILL.
//   DONE -> IDLE after one cycle; done_o=1 in DONE only.
//  s_ready_o = (state==FILL); no beat is accepted in IDLE/EMIT/DONE. Accept = s_valid_i & s_ready_o.
//  Packing: beat k of a word goes to bits [k*extInterfaceWidth +: extInterfaceWidth] (beat 0 at LSB).
//   Lanes not filled when s_last_i ends a word early are zero. Pack register clears after each emit.
//  Latency: write strobe is asserted in the cycle after the completing beat is accepted. Peak throughput is
//   8 beats + 1 emit cycle per word (9 cycles/word); bubbles are allowed.
//  Address: word m is written to (base_addr_i + m) mod wordsTotal; wraps from wordsTotal-1 to 0.
//   No overwrite protection; the controller must bound num_words_i to wordsTotal.
//  word_count_o increments on each completed write handshake; it holds its value after DONE until the next start.
//  s_last_i before num_words_i is reached ends the transfer early: pad, emit, DONE.
//   Further beats are then not accepted.
//  start_i while busy_o=1 or in DONE: ignored. s_last_i with s_valid_i=0: ignored.
// TESTING
//  T1 base=0,num=1, beats 0x00..0x07 back-to-back -> one write: addr 0, data {0x07,...,0x00} (beat0 at LSB),
//     m_wr_en_o 1 cycle after beat 7, done_o pulses, count=1
//  T2 base=30,num=4, 32 beats, m_ready_i=1 -> writes at addr 30,31,0,1; count=4; 36 cycles FILL->DONE
//  T3 num=2, s_last_i on beat 3 of word 0 -> one write with lanes 4..7 zero, done_o, count=1, s_ready_o low after
//  T4 m_ready_i low 5 cycles during EMIT -> m_wr_* held stable, s_ready_o=0, no beat lost or duplicated
//  T5 rst high during beat 4 of word 1 -> all outputs 0 next cycle, no write issued, fresh start works
//  T6 num=0 start -> no write, done_o the cycle after start; start_i pulses during FILL ignored

Source files
------------

// File: rtl/act_ingest_packer.sv
// Packs a narrow valid/ready activation stream into full-width buffer words and writes
// them to consecutive (wrapping) word addresses of the activation buffer.
module act_ingest_packer #(
  parameter int unsigned extInterfaceWidth = 32,
  parameter int unsigned intInterfaceWidth = 256,
  parameter int unsigned dataSize          = 8,
  parameter int unsigned depth             = 1024,
  parameter int unsigned addrWidth         = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [addrWidth-1:0]         base_addr_i,
  input  logic [addrWidth-1:0]         num_words_i,
  input  logic [extInterfaceWidth-1:0] s_data_i,
  input  logic                         s_valid_i,
  input  logic                         s_last_i,
  output logic                         s_ready_o,
  output logic [intInterfaceWidth-1:0] m_wr_data_o,
  output logic [addrWidth-1:0]         m_wr_addr_o,
  output logic                         m_wr_en_o,
  input  logic                         m_ready_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [addrWidth-1:0]         word_count_o
);

  localparam int unsigned BeatsPerWord = intInterfaceWidth / extInterfaceWidth;
  localparam int unsigned BeatIdxW     = (BeatsPerWord > 1) ? $clog2(BeatsPerWord) : 1;
  localparam int unsigned WordsTotal   = depth * dataSize / intInterfaceWidth;

  localparam logic [addrWidth-1:0] WordsTotalA = addrWidth'(WordsTotal);
  localparam logic [addrWidth-1:0] LastAddr    = addrWidth'(WordsTotal - 1);
  localparam logic [BeatIdxW-1:0]  LastBeat    = BeatIdxW'(BeatsPerWord - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFill = 2'd1;
  localparam logic [1:0] StEmit = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]                   r_state,     w_state_d;
  logic [BeatIdxW-1:0]          r_beat_idx,  w_beat_idx_d;
  logic [intInterfaceWidth-1:0] r_pack,      w_pack_d;
  logic [addrWidth-1:0]         r_addr,      w_addr_d;
  logic [addrWidth-1:0]         r_count,     w_count_d;
  logic [addrWidth-1:0]         r_num,       w_num_d;
  logic                         r_last_seen, w_last_seen_d;

  logic                         w_accept;
  logic [addrWidth-1:0]         w_count_inc;

  assign w_accept    = s_valid_i & (r_state == StFill);
  assign w_count_inc = r_count + 1'b1;

  always_comb begin
    w_state_d     = r_state;
    w_beat_idx_d  = r_beat_idx;
    w_pack_d      = r_pack;
    w_addr_d      = r_addr;
    w_count_d     = r_count;
    w_num_d       = r_num;
    w_last_seen_d = r_last_seen;
    case (r_state)
      StIdle: begin
        if (start_i) begin
          w_count_d     = '0;
          w_addr_d      = base_addr_i % WordsTotalA;
          w_num_d       = num_words_i;
          w_last_seen_d = 1'b0;
          w_beat_idx_d  = '0;
          w_pack_d      = '0;
          w_state_d     = (num_words_i == '0) ? StDone : StFill;
        end
      end
      StFill: begin
        if (w_accept) begin
          for (int unsigned k = 0; k < BeatsPerWord; k++) begin
            if (r_beat_idx == BeatIdxW'(k)) begin
              w_pack_d[k*extInterfaceWidth +: extInterfaceWidth] = s_data_i;
            end
          end
          // An early last leaves the upper lanes at zero from the post-emit clear.
          if (r_beat_idx == LastBeat || s_last_i) begin
            w_state_d     = StEmit;
            w_beat_idx_d  = '0;
            w_last_seen_d = s_last_i;
          end else begin
            w_beat_idx_d = r_beat_idx + 1'b1;
          end
        end
      end
      StEmit: begin
        if (m_ready_i) begin
          w_count_d = w_count_inc;
          w_addr_d  = (r_addr == LastAddr) ? '0 : r_addr + 1'b1;
          w_pack_d  = '0;
          w_state_d = (w_count_inc == r_num || r_last_seen) ? StDone : StFill;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_beat_idx  <= '0;
      r_pack      <= '0;
      r_addr      <= '0;
      r_count     <= '0;
      r_num       <= '0;
      r_last_seen <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_beat_idx  <= w_beat_idx_d;
      r_pack      <= w_pack_d;
      r_addr      <= w_addr_d;
      r_count     <= w_count_d;
      r_num       <= w_num_d;
      r_last_seen <= w_last_seen_d;
    end
  end

  assign s_ready_o    = (r_state == StFill);
  assign m_wr_en_o    = (r_state == StEmit);
  assign busy_o       = (r_state == StFill) || (r_state == StEmit);
  assign done_o       = (r_state == StDone);
  assign m_wr_data_o  = r_pack;
  assign m_wr_addr_o  = r_addr;
  assign word_count_o = r_count;

endmodule

// File: tb/tb_act_ingest_packer.sv
// Scoreboard bench for act_ingest_packer: stimulus queues expected writes, a monitor
// pops and compares them on every write handshake.
module tb_act_ingest_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [31:0]  base_addr_i;
  logic [31:0]  num_words_i;
  logic [31:0]  s_data_i;
  logic         s_valid_i;
  logic         s_last_i;
  logic         s_ready_o;
  logic [255:0] m_wr_data_o;
  logic [31:0]  m_wr_addr_o;
  logic         m_wr_en_o;
  logic         m_ready_i;
  logic         busy_o;
  logic         done_o;
  logic [31:0]  word_count_o;

  always #5 clk = ~clk;

  act_ingest_packer dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .num_words_i (num_words_i),
    .s_data_i    (s_data_i),
    .s_valid_i   (s_valid_i),
    .s_last_i    (s_last_i),
    .s_ready_o   (s_ready_o),
    .m_wr_data_o (m_wr_data_o),
    .m_wr_addr_o (m_wr_addr_o),
    .m_wr_en_o   (m_wr_en_o),
    .m_ready_i   (m_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .word_count_o(word_count_o)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  busy_cycles = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every completed write handshake must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && m_wr_en_o && m_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 m_wr_addr_o, m_wr_data_o);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 256'(m_wr_addr_o), 256'(e.addr));
        check("wr_data", m_wr_data_o, e.data);
      end
    end
    if (busy_o) busy_cycles++;
  end

  task automatic push_word(input logic [31:0] addr, input logic [31:0] first, input int nbeats);
    wr_t e;
    e.addr = addr;
    e.data = '0;
    for (int k = 0; k < nbeats; k++) e.data[k*32 +: 32] = first + 32'(k);
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [31:0] base, input logic [31:0] num);
    start_i     = 1'b1;
    base_addr_i = base;
    num_words_i = num;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Holds the beat until it is accepted; returns just after the accepting edge.
  task automatic send_beat(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    s_data_i  = d;
    s_valid_i = 1'b1;
    s_last_i  = last;
    forever begin
      @(negedge clk);
      if (s_ready_o) break;
      n++;
      if (n > 100) begin
        checks++;
        failures++;
        $display("FAIL beat_timeout: got no s_ready_o expected acceptance of %0h", d);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_beats();
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (done_o) break;
      n++;
      if (n > 200) break;
    end
    check(name, 256'(done_o), 256'(1));
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; base_addr_i = '0; num_words_i = '0;
    s_data_i = '0; s_valid_i = 1'b0; s_last_i = 1'b0; m_ready_i = 1'b1;
    @(negedge clk);
    check("reset_outputs", {m_wr_data_o, 1'b0}, '0);
    check("reset_ctrl", 256'({s_ready_o, m_wr_en_o, busy_o, done_o, m_wr_addr_o, word_count_o}),
          '0);
    @(posedge clk); #1; rst = 1'b0;

    // T1: single word, strobe one cycle after beat 7, done pulse
    do_start(32'd0, 32'd1);
    push_word(32'd0, 32'h0, 8);
    for (int k = 0; k < 8; k++) send_beat(32'(k), 1'b0);
    idle_beats();
    @(negedge clk);
    check("t1_wr_en_latency", 256'(m_wr_en_o), 256'(1));
    check("t1_data_literal", m_wr_data_o,
          256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
    wait_done("t1_done");
    check("t1_count", 256'(word_count_o), 256'(1));
    @(negedge clk);
    check("t1_done_pulse", 256'(done_o), 256'(0));
    check("t1_count_hold", 256'(word_count_o), 256'(1));

    // T2: four words wrapping the address space, 36 busy cycles
    busy_cycles = 0;
    do_start(32'd30, 32'd4);
    push_word(32'd30, 32'h100, 8);
    push_word(32'd31, 32'h108, 8);
    push_word(32'd0,  32'h110, 8);
    push_word(32'd1,  32'h118, 8);
    for (int k = 0; k < 32; k++) send_beat(32'h100 + 32'(k), 1'b0);
    idle_beats();
    wait_done("t2_done");
    check("t2_count", 256'(word_count_o), 256'(4));
    check("t2_busy_cycles", 256'(busy_cycles), 256'(36));

    // T3: early last pads the word with zero lanes and ends the transfer
    @(posedge clk); #1;
    do_start(32'd3, 32'd2);
    push_word(32'd3, 32'hA0, 4);
    for (int k = 0; k < 4; k++) send_beat(32'hA0 + 32'(k), k == 3);
    s_data_i = 32'hDEAD; s_last_i = 1'b0;
    wait_done("t3_done");
    check("t3_count", 256'(word_count_o), 256'(1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_no_accept", 256'(s_ready_o), 256'(0));
    end
    idle_beats();

    // T4: backpressure in EMIT holds the write stable
    @(posedge clk); #1;
    do_start(32'd8, 32'd2);
    push_word(32'd8, 32'h200, 8);
    push_word(32'd9, 32'h208, 8);
    for (int k = 0; k < 8; k++) send_beat(32'h200 + 32'(k), 1'b0);
    m_ready_i = 1'b0;
    s_data_i  = 32'h208;
    repeat (5) begin
      @(negedge clk);
      check("t4_hold_en", 256'(m_wr_en_o), 256'(1));
      check("t4_hold_addr", 256'(m_wr_addr_o), 256'(8));
      check("t4_hold_ready", 256'(s_ready_o), 256'(0));
    end
    check("t4_hold_data", m_wr_data_o,
          256'h00000207_00000206_00000205_00000204_00000203_00000202_00000201_00000200);
    @(posedge clk); #1;
    m_ready_i = 1'b1;
    for (int k = 8; k < 16; k++) send_beat(32'h200 + 32'(k), 1'b0);
    idle_beats();
    wait_done("t4_done");
    check("t4_count", 256'(word_count_o), 256'(2));

    // T5: reset during word 1 drops the partial word
    @(posedge clk); #1;
    do_start(32'd5, 32'd3);
    push_word(32'd5, 32'h300, 8);
    for (int k = 0; k < 12; k++) send_beat(32'h300 + 32'(k), 1'b0);
    s_data_i = 32'h30C;
    rst = 1'b1;
    #1;
    check("t5_rst_ctrl", 256'({s_ready_o, m_wr_en_o, busy_o, done_o, m_wr_addr_o, word_count_o}),
          '0);
    @(negedge clk);
    check("t5_rst_data", m_wr_data_o, '0);
    check("t5_rst_busy", 256'(busy_o), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle_beats();
    do_start(32'd2, 32'd1);
    push_word(32'd2, 32'h400, 8);
    for (int k = 0; k < 8; k++) send_beat(32'h400 + 32'(k), 1'b0);
    idle_beats();
    wait_done("t5_done");
    check("t5_count", 256'(word_count_o), 256'(1));

    // T6: zero-length start, then a start pulse during FILL is ignored
    @(posedge clk); #1;
    do_start(32'd0, 32'd0);
    @(negedge clk);
    check("t6_zero_done", 256'(done_o), 256'(1));
    check("t6_zero_no_write", 256'(m_wr_en_o), 256'(0));
    @(negedge clk);
    check("t6_zero_count", 256'(word_count_o), 256'(0));
    @(posedge clk); #1;
    do_start(32'd10, 32'd1);
    push_word(32'd10, 32'h500, 8);
    for (int k = 0; k < 3; k++) send_beat(32'h500 + 32'(k), 1'b0);
    start_i = 1'b1; base_addr_i = 32'd20; num_words_i = 32'd5;
    send_beat(32'h503, 1'b0);
    start_i = 1'b0;
    for (int k = 4; k < 8; k++) send_beat(32'h500 + 32'(k), 1'b0);
    idle_beats();
    wait_done("t6_done");
    check("t6_count", 256'(word_count_o), 256'(1));

    repeat (3) @(negedge clk);
    check("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
